// File: rtl/edge_trig_pkg.sv
// edge_trig_pkg: edge mode encodings and the per-channel detect function.
// Shared by edge_trig_channel and edge_trigger_bank; EDGE_TRIG_SYNC_EN lives in the channel.
package edge_trig_pkg;
   localparam logic [1:0] MODE_OFF  = 2'b00;
   localparam logic [1:0] MODE_RISE = 2'b01;
   localparam logic [1:0] MODE_FALL = 2'b10;
   localparam logic [1:0] MODE_BOTH = 2'b11;

   function automatic logic edge_det(input logic [1:0] mode, input logic cur, input logic prev);
      return (mode == MODE_OFF)  ? 1'b0 :
             (mode == MODE_RISE) ? (cur & ~prev) :
             (mode == MODE_FALL) ? (~cur & prev) : (cur ^ prev);
   endfunction
endpackage

// File: rtl/edge_trig_channel.sv
// edge_trig_channel: one channel of edge detect, pulse stretch, pending flag and saturating count.
// EDGE_TRIG_SYNC_EN adds a 2-flop input synchronizer ahead of detection.
module edge_trig_channel
   import edge_trig_pkg::*;
#(
   parameter int CNT_W   = 8,
   parameter int STRETCH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in,
   input  logic [1:0]       mode,
   input  logic             clr,
   output logic             out,
   output logic             pend,
   output logic [CNT_W-1:0] cnt
);
   localparam int SW = $clog2(STRETCH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             cur, det;
   logic             prev_q;
   logic [SW-1:0]    str_q, str_d;
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef EDGE_TRIG_SYNC_EN
   logic [1:0] sync_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[0], in};
   assign cur = sync_q[1];
`else
   assign cur = in;
`endif

   // a detect in the clear cycle survives as a fresh event of count 1
   always_comb begin
      det    = edge_det(mode, cur, prev_q);
      str_d  = det ? SW'(STRETCH) : (str_q != '0) ? str_q - SW'(1) : '0;
      pend_d = det | (pend_q & ~clr);
      cnt_d  = clr ? CNT_W'(det) : (det && cnt_q != CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         prev_q <= 1'b0;
         str_q  <= '0;
         pend_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         prev_q <= cur;
         str_q  <= str_d;
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end

   assign out  = str_q != '0;
   assign pend = pend_q;
   assign cnt  = cnt_q;
endmodule

// File: rtl/edge_trigger_bank.sv
// edge_trigger_bank: CH edge/toggle triggers with stretched pulses and a valid/ready event record port.
// Define EDGE_TRIG_SYNC_EN to synchronize the raw inputs (adds 2 cycles of latency).
module edge_trigger_bank
   import edge_trig_pkg::*;
#(
   parameter int CH      = 4,
   parameter int CNT_W   = 8,
   parameter int STRETCH = 1,
   localparam int CW     = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CH-1:0]     in,
   input  logic [2*CH-1:0]   mode,
   output logic [CH-1:0]     out,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [CW-1:0]     evt_ch,
   output logic [CNT_W-1:0]  evt_cnt
);
   logic [CH-1:0]            pend, clr;
   logic [CH-1:0][CNT_W-1:0] cnt;
   logic [CW-1:0]            sel, evt_ch_q, evt_ch_d;
   logic [CNT_W-1:0]         evt_cnt_q, evt_cnt_d;
   logic                     evt_valid_q, evt_valid_d, take;

   genvar i;
   for (i = 0; i < CH; i++) begin : g_ch
      edge_trig_channel #(.CNT_W(CNT_W), .STRETCH(STRETCH)) u_ch (
         .clk  (clk),
         .rst  (rst),
         .in   (in[i]),
         .mode (mode[2*i +: 2]),
         .clr  (clr[i]),
         .out  (out[i]),
         .pend (pend[i]),
         .cnt  (cnt[i])
      );
   end

   // lowest pending index wins; the record slot refills when empty or being accepted
   always_comb begin
      sel = '0;
      for (int k = CH - 1; k >= 0; k--) sel = pend[k] ? CW'(k) : sel;
      take        = (!evt_valid_q || evt_ready) && (pend != '0);
      clr         = take ? (CH'(1) << sel) : '0;
      evt_valid_d = (!evt_valid_q || evt_ready) ? (pend != '0) : evt_valid_q;
      evt_ch_d    = take ? sel : evt_ch_q;
      evt_cnt_d   = take ? cnt[sel] : evt_cnt_q;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         evt_valid_q <= 1'b0;
         evt_ch_q    <= '0;
         evt_cnt_q   <= '0;
      end else begin
         evt_valid_q <= evt_valid_d;
         evt_ch_q    <= evt_ch_d;
         evt_cnt_q   <= evt_cnt_d;
      end

   assign evt_valid = evt_valid_q;
   assign evt_ch    = evt_ch_q;
   assign evt_cnt   = evt_cnt_q;
endmodule
